// File: rtl/arcade_input_mux.sv
// Player-input front end: merges PS/2 key events and MiSTer joystick words into one control byte per player.
// Optional macro STICK_4WAY_EN restricts each stick to 4-way with a held-direction memory.
module arcade_input_mux #(
   parameter int PLAYERS        = 2,
   parameter int COIN_PULSE_CYC = 2457600,
   parameter int ACTIVE_LOW     = 0
) (
   input  logic                  clk_49m,
   input  logic                  reset,
   input  logic [10:0]           ps2_key,
   input  logic [16*PLAYERS-1:0] joystick,
   input  logic                  kbd_all,
   output logic [8*PLAYERS-1:0]  ctrl_out,
   output logic                  service,
   output logic                  pause
);
   localparam int            CW        = $clog2(COIN_PULSE_CYC + 1);
   localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE_CYC);
   localparam logic          INV       = (ACTIVE_LOW != 0);

   logic       toggle_reg;
   logic [7:0] key_p1_reg;
   logic [7:0] key_p2_reg;
   logic       service_key_reg;
   logic       pause_key_reg;
   logic       service_reg;
   logic       pause_reg;

   logic       key_event;
   logic       key_pressed;
   logic [7:0] p1_hit;
   logic [7:0] p2_hit;
   logic       service_hit;
   logic       pause_hit;
   logic       joy_pause;

   // Hit vectors use the control-byte bit order: {coin, start, fire2, fire1, left, down, right, up}.
   always_comb begin
      key_event   = ps2_key[10] ^ toggle_reg;
      key_pressed = ps2_key[9];
      p1_hit      = 8'h00;
      p2_hit      = 8'h00;
      service_hit = 1'b0;
      pause_hit   = 1'b0;
      case (ps2_key[8:0])
         9'h175:  p1_hit[0] = 1'b1;
         9'h174:  p1_hit[1] = 1'b1;
         9'h172:  p1_hit[2] = 1'b1;
         9'h16B:  p1_hit[3] = 1'b1;
         9'h014:  p1_hit[4] = 1'b1;
         9'h011:  p1_hit[5] = 1'b1;
         9'h016:  p1_hit[6] = 1'b1;
         9'h02E:  p1_hit[7] = 1'b1;
         9'h02D:  p2_hit[0] = 1'b1;
         9'h034:  p2_hit[1] = 1'b1;
         9'h02B:  p2_hit[2] = 1'b1;
         9'h023:  p2_hit[3] = 1'b1;
         9'h01C:  p2_hit[4] = 1'b1;
         9'h01B:  p2_hit[5] = 1'b1;
         9'h01E:  p2_hit[6] = 1'b1;
         9'h036:  p2_hit[7] = 1'b1;
         9'h046:  service_hit = 1'b1;
         9'h04D:  pause_hit   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         toggle_reg      <= ps2_key[10];
         key_p1_reg      <= 8'h00;
         key_p2_reg      <= 8'h00;
         service_key_reg <= 1'b0;
         pause_key_reg   <= 1'b0;
      end else begin
         toggle_reg <= ps2_key[10];
         if (key_event) begin
            key_p1_reg <= (key_p1_reg & ~p1_hit) | (p1_hit & {8{key_pressed}});
            key_p2_reg <= (key_p2_reg & ~p2_hit) | (p2_hit & {8{key_pressed}});
            if (service_hit) service_key_reg <= key_pressed;
            if (pause_hit)   pause_key_reg   <= key_pressed;
         end
      end
   end

   always_comb begin
      joy_pause = 1'b0;
      for (int i = 0; i < PLAYERS; i++) begin
         joy_pause = joy_pause | joystick[16*i+10];
      end
   end

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         service_reg <= 1'b0;
         pause_reg   <= 1'b0;
      end else begin
         service_reg <= service_key_reg;
         pause_reg   <= pause_key_reg | joy_pause;
      end
   end

   wire [8*PLAYERS-1:0] ctrl_int;

   genvar gi;
   generate
      for (gi = 0; gi < PLAYERS; gi++) begin : g_player
         logic [15:0]   joy;
         logic [7:0]    own_keys;
         logic [7:0]    raw;
         logic [3:0]    dir_c;
         logic [3:0]    dir_out;
         logic          coin_rise;
         logic [6:0]    ctrl_reg;
         logic          coin_prev_reg;
         logic [CW-1:0] coin_cnt_reg;
         wire           unused_bits;

         assign joy         = joystick[16*gi +: 16];
         assign unused_bits = ^{joy[15:9], joy[6]};

         if (gi == 0) begin : g_keys_p1
            assign own_keys = key_p1_reg;
         end else if (gi == 1) begin : g_keys_p2
            assign own_keys = key_p2_reg;
         end else begin : g_keys_none
            assign own_keys = 8'h00;
         end

         assign raw = {joy[7], joy[8], joy[5], joy[4], joy[1], joy[2], joy[0], joy[3]}
                    | own_keys | (kbd_all ? key_p1_reg : 8'h00);

         // Opposite directions pressed together cancel each other out.
         always_comb begin
            dir_c = raw[3:0];
            if (raw[0] && raw[2]) begin
               dir_c[0] = 1'b0;
               dir_c[2] = 1'b0;
            end
            if (raw[1] && raw[3]) begin
               dir_c[1] = 1'b0;
               dir_c[3] = 1'b0;
            end
         end

`ifdef STICK_4WAY_EN
         logic [3:0] held_reg;
         logic [3:0] prev_reg;
         logic [3:0] fresh;
         logic [2:0] dir_count;

         // On a diagonal keep the held direction, else take the newly pressed axis (vertical first).
         always_comb begin
            dir_count = 3'(dir_c[0]) + 3'(dir_c[1]) + 3'(dir_c[2]) + 3'(dir_c[3]);
            fresh     = dir_c & ~prev_reg;
            dir_out   = 4'b0000;
            if (dir_count == 3'd1) begin
               dir_out = dir_c;
            end else if (dir_count == 3'd2) begin
               if ((held_reg & dir_c) != 4'b0000) begin
                  dir_out = held_reg & dir_c;
               end else if ((fresh & 4'b0101) != 4'b0000) begin
                  dir_out = dir_c & 4'b0101;
               end else if (fresh != 4'b0000) begin
                  dir_out = dir_c & 4'b1010;
               end else begin
                  dir_out = dir_c & 4'b0101;
               end
            end
         end

         always_ff @(posedge clk_49m) begin
            if (reset) begin
               held_reg <= 4'b0000;
               prev_reg <= 4'b0000;
            end else begin
               held_reg <= dir_out;
               prev_reg <= dir_c;
            end
         end
`else
         assign dir_out = dir_c;
`endif

         assign coin_rise = raw[7] & ~coin_prev_reg;

         // coin_prev_reg comes out of reset set so a coin already held must be released first.
         always_ff @(posedge clk_49m) begin
            if (reset) begin
               coin_prev_reg <= 1'b1;
               coin_cnt_reg  <= '0;
               ctrl_reg      <= 7'h00;
            end else begin
               coin_prev_reg <= raw[7];
               ctrl_reg      <= {raw[6:4], dir_out};
               if (coin_cnt_reg != '0) begin
                  coin_cnt_reg <= coin_cnt_reg - CW'(1);
               end else if (coin_rise) begin
                  coin_cnt_reg <= COIN_LOAD;
               end
            end
         end

         assign ctrl_int[8*gi +: 8] = {(coin_cnt_reg != '0), ctrl_reg};
      end
   endgenerate

   assign ctrl_out = ctrl_int ^ {(8*PLAYERS){INV}};
   assign service  = service_reg ^ INV;
   assign pause    = pause_reg ^ INV;

endmodule

// File: tb/tb_arcade_input_mux.sv
// Bench for arcade_input_mux: directed steps with literal expectations, then random stimulus
// checked every cycle against a behavioural model (key table lookup, coin pulse by start cycle).
module tb_arcade_input_mux;
   localparam int P = 2;
   localparam int C = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [31:0] joystick;
   logic        kbd_all;
   wire  [15:0] ctrl_out;
   wire  [15:0] ctrl_lo;
   wire         service, pause, service_lo, pause_lo;

   arcade_input_mux #(.PLAYERS(P), .COIN_PULSE_CYC(C), .ACTIVE_LOW(0)) dut (
      .clk_49m(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
      .kbd_all(kbd_all), .ctrl_out(ctrl_out), .service(service), .pause(pause));

   arcade_input_mux #(.PLAYERS(P), .COIN_PULSE_CYC(C), .ACTIVE_LOW(1)) dut_lo (
      .clk_49m(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
      .kbd_all(kbd_all), .ctrl_out(ctrl_lo), .service(service_lo), .pause(pause_lo));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: key table indexed by {ext, code}, per-player coin start cycle.
   bit         key_down [512];
   bit         mdl_tog;
   bit         mdl_valid = 1'b0;
   int         coin_start [P] = '{-100000, -100000};
   bit         coin_last [P];
   logic [7:0] exp_ctrl [P];
   logic       exp_svc, exp_pau;
   logic [3:0] m_held [P];
   logic [3:0] m_prev [P];

   // Functions in control-byte order: up, right, down, left, fire1, fire2, start, coin.
   int key_map [2][8] = '{'{'h175, 'h174, 'h172, 'h16B, 'h014, 'h011, 'h016, 'h02E},
                          '{'h02D, 'h034, 'h02B, 'h023, 'h01C, 'h01B, 'h01E, 'h036}};
   int joy_map [8]    = '{3, 0, 2, 1, 4, 5, 8, 7};

   wire [15:0] exp_word = {exp_ctrl[1], exp_ctrl[0]};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic [7:0] r;
      logic [3:0] dc, o;
`ifdef STICK_4WAY_EN
      logic [3:0] fresh;
`endif
      cyc++;
      if (reset) begin
         foreach (key_down[k]) key_down[k] = 1'b0;
         mdl_tog = ps2_key[10];
         for (int p = 0; p < P; p++) begin
            coin_start[p] = -100000;
            coin_last[p]  = 1'b1;
            exp_ctrl[p]   = 8'h00;
            m_held[p]     = 4'h0;
            m_prev[p]     = 4'h0;
         end
         exp_svc   = 1'b0;
         exp_pau   = 1'b0;
         mdl_valid = 1'b1;
      end else begin
         exp_svc = key_down['h046];
         exp_pau = key_down['h04D];
         for (int p = 0; p < P; p++) begin
            for (int f = 0; f < 8; f++) begin
               r[f] = joystick[16*p + joy_map[f]];
               if (p < 2 && key_down[key_map[p][f]]) r[f] = 1'b1;
               if (kbd_all && key_down[key_map[0][f]]) r[f] = 1'b1;
            end
            if (joystick[16*p + 10]) exp_pau = 1'b1;
            dc = r[3:0];
            if (r[0] && r[2]) begin dc[0] = 1'b0; dc[2] = 1'b0; end
            if (r[1] && r[3]) begin dc[1] = 1'b0; dc[3] = 1'b0; end
            o = dc;
`ifdef STICK_4WAY_EN
            if ($countones(dc) == 2) begin
               if ((m_held[p] & dc) != 4'h0) o = m_held[p];
               else begin
                  fresh = dc & ~m_prev[p];
                  if ((fresh & 4'b0101) != 4'h0) o = dc & 4'b0101;
                  else if (fresh != 4'h0)        o = dc & 4'b1010;
                  else                           o = dc & 4'b0101;
               end
            end
            m_held[p] = o;
            m_prev[p] = dc;
`endif
            if (!exp_ctrl[p][7] && r[7] && !coin_last[p]) coin_start[p] = cyc;
            coin_last[p] = r[7];
            exp_ctrl[p]  = {((cyc - coin_start[p]) < C), r[6:4], o};
         end
         if (ps2_key[10] != mdl_tog) key_down[ps2_key[8:0]] = ps2_key[9];
         mdl_tog = ps2_key[10];
      end
   endtask

   always @(negedge clk) begin
      if (mdl_valid) begin
         check("ctrl_out", {16'h0, ctrl_out}, {16'h0, exp_word});
         check("ctrl_lo", {16'h0, ctrl_lo}, {16'h0, ~exp_word});
         check("service", {31'h0, service}, {31'h0, exp_svc});
         check("pause", {31'h0, pause}, {31'h0, exp_pau});
         check("service_lo", {31'h0, service_lo}, {31'h0, ~exp_svc});
         check("pause_lo", {31'h0, pause_lo}, {31'h0, ~exp_pau});
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic key(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
      $display("key event code=%03h pressed=%0d", code, pressed);
   endtask

   int hi;

   initial begin
      reset    = 1'b1;
      ps2_key  = 11'h000;
      joystick = 32'h0;
      kbd_all  = 1'b0;
      repeat (3) tick();
      check("rst_ctrl", {16'h0, ctrl_out}, 32'h0000);
      check("rst_ctrl_lo", {16'h0, ctrl_lo}, 32'hFFFF);
      check("rst_svc_pau", {30'h0, service, pause}, 32'h0);
      check("rst_svc_pau_lo", {30'h0, service_lo, pause_lo}, 32'h3);
      $display("step reset done");
      reset = 1'b0;
      repeat (2) tick();

      joystick[3] = 1'b1;
      tick();
      check("joy_up", {16'h0, ctrl_out}, 32'h0001);
      joystick[2] = 1'b1;
      tick();
      check("joy_up_down_cancel", {16'h0, ctrl_out}, 32'h0000);
      joystick = 32'h0;
      tick();
      $display("step joystick up/cancel done");

      key(9'h175, 1'b1);
      tick();
      check("key_up_lat1", {16'h0, ctrl_out}, 32'h0000);
      tick();
      check("key_up_lat2", {16'h0, ctrl_out}, 32'h0001);
      key(9'h175, 1'b0);
      repeat (2) tick();
      check("key_up_release", {16'h0, ctrl_out}, 32'h0000);
      key(9'h075, 1'b1);
      repeat (2) tick();
      check("key_75_noext", {16'h0, ctrl_out}, 32'h0000);
      key(9'h075, 1'b0);
      tick();
      key(9'h02D, 1'b1);
      repeat (2) tick();
      check("key_p2_up", {16'h0, ctrl_out}, 32'h0100);
      key(9'h02D, 1'b0);
      repeat (2) tick();

      joystick[7] = 1'b1;
      hi = 0;
      repeat (20) begin
         tick();
         if (ctrl_out[7]) hi++;
      end
      check("coin_hold_width", hi, 8);
      check("coin_hold_end", {31'h0, ctrl_out[7]}, 32'h0);
      joystick[7] = 1'b0;
      repeat (2) tick();
      $display("step coin hold done");

      joystick[7] = 1'b1;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ctrl_out[7]) hi++;
         if (i == 4) joystick[7] = 1'b0;
         if (i == 5) joystick[7] = 1'b1;
      end
      check("coin_no_retrigger", hi, 8);
      joystick[7] = 1'b0;
      repeat (2) tick();

      joystick[7] = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("coin_reset_trunc", {31'h0, ctrl_out[7]}, 32'h0);
      reset = 1'b0;
      hi = 0;
      repeat (12) begin
         tick();
         if (ctrl_out[7]) hi++;
      end
      check("coin_held_after_reset", hi, 0);
      joystick[7] = 1'b0;
      tick();
      joystick[7] = 1'b1;
      tick();
      check("coin_rearm", {31'h0, ctrl_out[7]}, 32'h1);
      joystick[7] = 1'b0;
      repeat (10) tick();
      $display("step coin reset done");

      kbd_all = 1'b1;
      key(9'h014, 1'b1);
      repeat (2) tick();
      check("kbd_all_fire1", {16'h0, ctrl_out}, 32'h1010);
      kbd_all = 1'b0;
      tick();
      check("kbd_p1_fire1", {16'h0, ctrl_out}, 32'h0010);
      key(9'h014, 1'b0);
      repeat (2) tick();

      key(9'h046, 1'b1);
      repeat (2) tick();
      check("service_key", {30'h0, service, service_lo}, 32'h2);
      key(9'h046, 1'b0);
      repeat (2) tick();
      joystick[26] = 1'b1;
      tick();
      check("pause_joy_p2", {30'h0, pause, pause_lo}, 32'h2);
      joystick[26] = 1'b0;
      tick();

`ifdef STICK_4WAY_EN
      joystick[0] = 1'b1;
      tick();
      check("4way_right", {28'h0, ctrl_out[3:0]}, 32'h2);
      joystick[3] = 1'b1;
      tick();
      check("4way_hold_right", {28'h0, ctrl_out[3:0]}, 32'h2);
      joystick[0] = 1'b0;
      tick();
      check("4way_up", {28'h0, ctrl_out[3:0]}, 32'h1);
      joystick = 32'h0;
      tick();
      joystick[0] = 1'b1;
      joystick[3] = 1'b1;
      tick();
      check("4way_tie_vertical", {28'h0, ctrl_out[3:0]}, 32'h1);
      joystick = 32'h0;
      tick();
      $display("step 4-way done");
`endif

      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 3) == 0) joystick[$urandom_range(0, 31)] ^= 1'b1;
         if ($urandom_range(0, 199) == 0) kbd_all = ~kbd_all;
         if ($urandom_range(0, 11) == 0) begin
            int idx;
            logic [8:0] code;
            idx = $urandom_range(0, 19);
            if (idx < 16)       code = 9'(key_map[idx / 8][idx % 8]);
            else if (idx == 16) code = 9'h046;
            else if (idx == 17) code = 9'h04D;
            else                code = 9'($urandom_range(0, 511));
            key(code, 1'($urandom_range(0, 1)));
         end
         tick();
      end
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/arcade_input_mux.md
Name: arcade_input_mux

Overview:
- Parametrised player-input front end for arcade cores.
- Merges PS/2 keyboard events and per-player MiSTer joystick words into one control byte per player.
- Adds coin pulse shaping, opposite-direction cancel, and selectable output polarity.
- Sits between hps_io and the game core; replaces ad-hoc per-core key/joystick glue.

Parameters:
PLAYERS, 2, number of player channels (1..4); keyboard maps P1 and P2 only.
COIN_PULSE_CYC, 2457600, coin output width in clk_49m cycles (50 ms at 49.152 MHz); must be >= 1.
ACTIVE_LOW, 0, 1 = invert every bit of ctrl_out, service and pause on output.

Ports:
clk_49m  in  1  system clock.
reset  in  1  synchronous, active-high.
ps2_key  in  11  hps_io key word: [10] toggle, [9] pressed, [8] extended, [7:0] code.
joystick  in  16*PLAYERS  player n occupies bits [16n+15:16n]; bit0 R, 1 L, 2 D, 3 U, 4 fire1, 5 fire2, 7 coin, 8 start, 10 pause.
kbd_all  in  1  1 = P1 keyboard set also drives every player.
ctrl_out  out  8*PLAYERS  per player: {coin, start, fire2, fire1, left, down, right, up}.
service  out  1  service key state.
pause  out  1  OR of pause key and all joystick pause bits.

Behaviour:
- Key event: detected when ps2_key[10] differs from its registered copy.
- Key lookup uses {ps2_key[8], code}. The matching key-state register loads ps2_key[9].
- P1 key map:
  - Arrows (ext 75/72/6B/74) are up/down/left/right.
  - 14 is fire1, 11 is fire2.
  - 16 is start P1, 2E is coin P1.
- P2 key map:
  - R/F/D/G (2D/2B/23/34) are up/down/left/right.
  - 1C is fire1, 1B is fire2.
  - 1E is start P2, 36 is coin P2.
- Other keys: 46 drives service, 4D drives pause. All unlisted codes are ignored.
- Merge: raw bit = key state OR joystick bit. With kbd_all=1, the P1 key set is also ORed into every player.
- Opposite cancel: if up and down are both raw-high, both outputs are 0. Same rule for left and right.
- Coin pulse, per player:
  - A rising edge of the raw coin bit loads the counter with COIN_PULSE_CYC.
  - The coin output is high while counter != 0. The counter decrements each cycle.
  - Edges that arrive while the counter is nonzero are ignored (no retrigger, no extension).
  - Holding coin produces exactly one pulse.
- Latency:
  - A joystick change in cycle n appears on ctrl_out in cycle n+1 (one register stage).
  - A ps2 toggle sampled in cycle n appears on ctrl_out in cycle n+2.
  - The coin pulse starts on the same stage timing.
- Polarity: with ACTIVE_LOW=1, all outputs are inverted after all processing.
- Reset:
  - Clears all key states, coin counters and edge registers.
  - Loads the toggle copy from ps2_key[10], so no spurious event occurs after reset.
  - Outputs go inactive in the first cycle reset is sampled high: all 0, or all 1 if ACTIVE_LOW.
  - Reset during a coin pulse truncates it.
  - After reset deasserts, a coin bit that is already held high does not fire until it is released and pressed again.
- Simultaneous events: a key event and a joystick change in the same cycle are both applied.
- PLAYERS>2: channels 2..3 are joystick-only, except when kbd_all=1.

Optional Feature:
STICK_4WAY_EN
- Defined: after opposite cancel, directions are restricted to 4-way.
  - Exactly one direction active: output it and store it as the held direction.
  - Zero directions active: output none and clear the held direction.
  - Two directions active (diagonal): output the held direction if it is one of the two. Otherwise output the newly asserted one, vertical wins on a tie.
  - Adds no latency.
- Undefined: directions pass through as 8-way. No held-direction registers exist.

Test Plan:
1. Reset, PLAYERS=2, ACTIVE_LOW=0 -> ctrl_out=16'h0000, service=0, pause=0. With ACTIVE_LOW=1 -> 16'hFFFF, service=1, pause=1.
2. joystick[3] set at cycle 10 -> ctrl_out[0]=1 at cycle 11. Setting joystick[2] as well -> ctrl_out[1:0]=2'b00 on the next cycle.
3. ps2_key toggles with {pressed=1, ext=1, code=75} -> P1 up=1 two cycles later. Release event -> 0. Code 75 with ext=0 -> no change.
4. COIN_PULSE_CYC=8; hold joystick[7] high for 20 cycles:
   - ctrl_out[7] is high for exactly 8 cycles, then stays 0.
   - Releasing and re-pressing at cycle 5 of the pulse does not extend it.
5. kbd_all=1, key 14 pressed -> fire1 high on P1 and P2. With kbd_all=0 -> P1 only.
6. STICK_4WAY_EN defined: right held, then up added -> output stays right. Release right -> up. Up+right pressed in the same cycle from idle -> up.
